// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: four-state-per-instruction control sequencer for the single-issue core
module multicycle_ctrl_fsm #(
    parameter int PROG_LEN = 20,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [3:0]       rt,
    input  logic [3:0]       rd,
    output logic             ir_load,
    output logic             pc_en,
    output logic             rf_we,
    output logic [3:0]       dest_reg,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] illegal_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [3:0]       rt_q, rt_d, rd_q, rd_d;
    logic [3:0]       aop_q, aop_d, dst_q, dst_d;
    logic             imm_q, imm_d, wr_q, wr_d, ill_q, ill_d, done_q, done_d;
    logic [CNT_W-1:0] icnt_q, icnt_d, lcnt_q, lcnt_d;
    logic [3:0]       dec_aop, dec_dst;
    logic             dec_imm, dec_valid, dec_nop, go, last, in_ex;

    // Decode the captured instruction fields into ALU controls and write permission
    always_comb begin
        dec_aop   = 4'd0;
        dec_dst   = 4'd0;
        dec_imm   = 1'b0;
        dec_valid = 1'b0;
        dec_nop   = 1'b0;
        if (op_q == 6'd0) begin
            dec_valid = (fn_q < 6'd8) || (fn_q == 6'd12) || (fn_q == 6'd13) || (fn_q == 6'd14);
            dec_nop   = fn_q == 6'd0;
            dec_aop   = dec_valid ? fn_q[3:0] : 4'd0;
            dec_dst   = dec_valid ? rd_q : 4'd0;
        end else if ((op_q >= 6'd1 && op_q <= 6'd5) || op_q == 6'd13 || op_q == 6'd14 || op_q == 6'd16) begin
            dec_valid = 1'b1;
            dec_imm   = 1'b1;
            dec_aop   = (op_q == 6'd16) ? 4'd15 : op_q[3:0];
            dec_dst   = rt_q;
        end
    end

    // Next-state, field capture, decode registration and run counters
    always_comb begin
        go     = !pause;
        last   = ({1'b0, icnt_q} + 1'b1) == (CNT_W + 1)'(PROG_LEN);
        state_d = state_q;
        op_d   = op_q;
        fn_d   = fn_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        aop_d  = aop_q;
        dst_d  = dst_q;
        imm_d  = imm_q;
        wr_d   = wr_q;
        ill_d  = ill_q;
        icnt_d = icnt_q;
        lcnt_d = lcnt_q;
        done_d = 1'b0;
        if (go) begin
            case (state_q)
                IDLE, HALT: if (start) begin
                    state_d = FETCH;
                    icnt_d  = '0;
                    lcnt_d  = '0;
                end
                FETCH: begin
                    state_d = DECODE;
                    op_d    = opcode;
                    fn_d    = funct;
                    rt_d    = rt;
                    rd_d    = rd;
                end
                DECODE: begin
                    state_d = EXEC;
                    aop_d   = dec_aop;
                    dst_d   = dec_dst;
                    imm_d   = dec_imm;
                    wr_d    = dec_valid && !dec_nop && dec_dst != 4'd0;
                    ill_d   = !dec_valid;
                end
                EXEC: state_d = WB;
                WB: begin
                    state_d = last ? HALT : FETCH;
                    done_d  = last;
                    icnt_d  = (&icnt_q) ? icnt_q : icnt_q + 1'b1;
                    lcnt_d  = (ill_q && !(&lcnt_q)) ? lcnt_q + 1'b1 : lcnt_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath-control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            fn_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            aop_q   <= '0;
            dst_q   <= '0;
            imm_q   <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            icnt_q  <= '0;
            lcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            aop_q   <= aop_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            icnt_q  <= icnt_d;
            lcnt_q  <= lcnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs: strobes gated by pause and by a reset in progress, controls only in EXEC/WB
    always_comb begin
        in_ex         = state_q == EXEC || state_q == WB;
        ir_load       = state_q == FETCH && !pause && !rst;
        pc_en         = state_q == WB && !pause && !rst;
        rf_we         = pc_en && wr_q;
        dest_reg      = in_ex ? dst_q : 4'd0;
        alu_op        = in_ex ? aop_q : 4'd0;
        alu_src_imm   = in_ex && imm_q;
        illegal       = in_ex && ill_q;
        busy          = state_q != IDLE && state_q != HALT;
        done          = done_q;
        instr_count   = icnt_q;
        illegal_count = lcnt_q;
    end
endmodule
